// File: rtl/dram_pad_sched_if.sv
// Command handshake bundle between the DRAM controller and dram_pad_sched.
interface dram_pad_sched_if;
  logic cmd_vld;
  logic cmd_rd;
  logic cmd_rdy;

  modport master (
    output cmd_vld,
    output cmd_rd,
    input  cmd_rdy
  );

  modport slave (
    input  cmd_vld,
    input  cmd_rd,
    output cmd_rdy
  );
endinterface

// File: rtl/dram_pad_sched.sv
// DRAM pad enable-window burst scheduler with a 2-entry command queue.
// Define DRAM_PAD_SCHED_TURNAROUND_EN to insert a 2-cycle gap on read/write turnaround.
module dram_pad_sched (
  input  logic                   clk,
  input  logic                   arst_l,
  dram_pad_sched_if.slave        cmd,
  input  logic                   cfg_bl4,
  input  logic [3:0]             cfg_rd_lat,
  input  logic [3:0]             cfg_wr_lat,
  input  logic                   cfg_clk_inv,
  input  logic                   err_clr,
  output logic                   dram_io_pad_enable,
  output logic                   dram_io_pad_clk_inv,
  output logic                   burst_length_four,
  output logic                   sched_busy,
  output logic                   sched_rd_done,
  output logic                   sched_wr_done,
  output logic                   sched_ovf
);

  typedef enum logic [1:0] {
    StIdle,
    StWait,
`ifdef DRAM_PAD_SCHED_TURNAROUND_EN
    StBurst,
    StGap
`else
    StBurst
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        cur_rd_q, cur_rd_d;
  logic [2:0]  cur_len_q, cur_len_d;

  // Queue entry layout: {rd, lat[3:0], len[2:0]}
  logic [7:0]  fifo_q [2];
  logic        wr_ptr_q, rd_ptr_q;
  logic [1:0]  count_q, count_d;

  logic        push, pop, load_head;
  logic [7:0]  head, entry;
  logic        head_rd;
  logic [3:0]  head_lat;
  logic [2:0]  head_len;
  logic        cfg_load;
  logic        pad_en_q, rd_done_q, wr_done_q, ovf_q;
  logic        clk_inv_q, bl4_q;

  assign cmd.cmd_rdy = (count_q != 2'd2);
  assign push        = cmd.cmd_vld & cmd.cmd_rdy;
  assign entry       = {cmd.cmd_rd, (cmd.cmd_rd ? cfg_rd_lat : cfg_wr_lat),
                        (bl4_q ? 3'd2 : 3'd4)};
  assign head        = fifo_q[rd_ptr_q];
  assign head_rd     = head[7];
  assign head_lat    = head[6:3];
  assign head_len    = head[2:0];
  assign cfg_load    = (state_q == StIdle) && (count_q == 2'd0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cur_rd_d  = cur_rd_q;
    cur_len_d = cur_len_q;
    load_head = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (count_q != 2'd0) load_head = 1'b1;
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = StBurst;
          cnt_d   = {1'b0, cur_len_q};
        end
      end
      StBurst: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          if (count_q == 2'd0) begin
            state_d = StIdle;
`ifdef DRAM_PAD_SCHED_TURNAROUND_EN
          end else if (head_rd != cur_rd_q) begin
            state_d = StGap;
            cnt_d   = 4'd2;
`endif
          end else begin
            load_head = 1'b1;
          end
        end
      end
`ifdef DRAM_PAD_SCHED_TURNAROUND_EN
      StGap: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) load_head = 1'b1;
      end
`endif
      default: state_d = StIdle;
    endcase
    // Head load is shared by IDLE, back-to-back BURST and the end of GAP.
    if (load_head) begin
      cur_rd_d  = head_rd;
      cur_len_d = head_len;
      if (head_lat == 4'd0) begin
        state_d = StBurst;
        cnt_d   = {1'b0, head_len};
      end else begin
        state_d = StWait;
        cnt_d   = head_lat;
      end
    end
  end

  assign pop = load_head;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      cur_rd_q  <= 1'b0;
      cur_len_q <= 3'd0;
      fifo_q[0] <= 8'd0;
      fifo_q[1] <= 8'd0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
      pad_en_q  <= 1'b0;
      rd_done_q <= 1'b0;
      wr_done_q <= 1'b0;
      ovf_q     <= 1'b0;
      clk_inv_q <= 1'b0;
      bl4_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cur_rd_q  <= cur_rd_d;
      cur_len_q <= cur_len_d;
      count_q   <= count_d;
      if (push) begin
        fifo_q[wr_ptr_q] <= entry;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      pad_en_q  <= (state_d == StBurst);
      rd_done_q <= (state_q == StBurst) && (cnt_q == 4'd1) && cur_rd_q;
      wr_done_q <= (state_q == StBurst) && (cnt_q == 4'd1) && !cur_rd_q;
      // A drop in the same cycle as err_clr keeps the flag set.
      if (cmd.cmd_vld && !cmd.cmd_rdy) ovf_q <= 1'b1;
      else if (err_clr)                 ovf_q <= 1'b0;
      if (cfg_load) begin
        clk_inv_q <= cfg_clk_inv;
        bl4_q     <= cfg_bl4;
      end
    end
  end

  assign dram_io_pad_enable  = pad_en_q;
  assign dram_io_pad_clk_inv = clk_inv_q;
  assign burst_length_four   = bl4_q;
  assign sched_busy          = (state_q != StIdle) || (count_q != 2'd0);
  assign sched_rd_done       = rd_done_q;
  assign sched_wr_done       = wr_done_q;
  assign sched_ovf           = ovf_q;

endmodule

// File: tb/tb_dram_pad_sched.sv
// Directed self-checking bench for dram_pad_sched.
module tb_dram_pad_sched;
  logic       clk;
  logic       arst_l;
  logic       cfg_bl4;
  logic [3:0] cfg_rd_lat;
  logic [3:0] cfg_wr_lat;
  logic       cfg_clk_inv;
  logic       err_clr;
  logic       dram_io_pad_enable;
  logic       dram_io_pad_clk_inv;
  logic       burst_length_four;
  logic       sched_busy;
  logic       sched_rd_done;
  logic       sched_wr_done;
  logic       sched_ovf;

  int n_cmp = 0;
  int n_err = 0;

  dram_pad_sched_if cmd_if ();

  dram_pad_sched dut (
    .clk                 (clk),
    .arst_l              (arst_l),
    .cmd                 (cmd_if),
    .cfg_bl4             (cfg_bl4),
    .cfg_rd_lat          (cfg_rd_lat),
    .cfg_wr_lat          (cfg_wr_lat),
    .cfg_clk_inv         (cfg_clk_inv),
    .err_clr             (err_clr),
    .dram_io_pad_enable  (dram_io_pad_enable),
    .dram_io_pad_clk_inv (dram_io_pad_clk_inv),
    .burst_length_four   (burst_length_four),
    .sched_busy          (sched_busy),
    .sched_rd_done       (sched_rd_done),
    .sched_wr_done       (sched_wr_done),
    .sched_ovf           (sched_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Read, lat 3, burst of 4: enable k=4..5 after the accept edge, done at k=6.
  task automatic run_rd3(input string tag);
    cfg_rd_lat = 4'd3;
    cfg_bl4    = 1'b1;
    cmd_if.cmd_rd = 1'b1;
    tick();
    tick();
    chk({tag, "_bl4"}, burst_length_four, 1'b1);
    cmd_if.cmd_vld = 1'b1;
    tick();
    cmd_if.cmd_vld = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      chk($sformatf("%s_en%0d", tag, k), dram_io_pad_enable, (k == 4 || k == 5));
      chk($sformatf("%s_rdd%0d", tag, k), sched_rd_done, (k == 6));
      chk($sformatf("%s_wrd%0d", tag, k), sched_wr_done, 1'b0);
      chk($sformatf("%s_busy%0d", tag, k), sched_busy, (k < 6));
      if (k < 6) tick();
    end
  endtask

  initial begin
    arst_l         = 1'b0;
    cmd_if.cmd_vld = 1'b0;
    cmd_if.cmd_rd  = 1'b0;
    cfg_bl4        = 1'b1;
    cfg_rd_lat     = 4'd3;
    cfg_wr_lat     = 4'd0;
    cfg_clk_inv    = 1'b0;
    err_clr        = 1'b0;
    #1;
    chk("rst_rdy", cmd_if.cmd_rdy, 1'b1);
    chk("rst_en", dram_io_pad_enable, 1'b0);
    chk("rst_busy", sched_busy, 1'b0);
    chk("rst_ovf", sched_ovf, 1'b0);
    chk("rst_bl4", burst_length_four, 1'b0);
    tick();
    tick();
    chk("rst_hold_bl4", burst_length_four, 1'b0);
    arst_l = 1'b1;

    // First read scenario
    run_rd3("rd3");

    // Back-to-back writes with overflow and err_clr
    cfg_bl4    = 1'b0;
    cfg_wr_lat = 4'd0;
    cmd_if.cmd_rd = 1'b0;
    tick();
    tick();
    chk("wr_bl8", burst_length_four, 1'b0);
    cmd_if.cmd_vld = 1'b1;
    for (int k = 0; k <= 13; k++) begin
      tick();
      if (k == 3) err_clr = 1'b1;
      if (k == 4) cmd_if.cmd_vld = 1'b0;
      if (k == 5) err_clr = 1'b0;
      chk($sformatf("wr_en%0d", k), dram_io_pad_enable, (k >= 1 && k <= 12));
      chk($sformatf("wr_done%0d", k), sched_wr_done, (k == 5 || k == 9 || k == 13));
      chk($sformatf("wr_rdy%0d", k), cmd_if.cmd_rdy, !(k >= 2 && k <= 4));
      chk($sformatf("wr_ovf%0d", k), sched_ovf, (k == 3 || k == 4));
      if (k == 13) chk("wr_busy_end", sched_busy, 1'b0);
    end

    // Read then write with zero latency: turnaround gap
    cfg_rd_lat = 4'd0;
    cmd_if.cmd_rd  = 1'b1;
    cmd_if.cmd_vld = 1'b1;
    for (int k = 0; k <= 7; k++) begin
      tick();
      if (k == 0) cmd_if.cmd_rd = 1'b0;
      if (k == 1) cmd_if.cmd_vld = 1'b0;
`ifdef DRAM_PAD_SCHED_TURNAROUND_EN
      chk($sformatf("ta_en%0d", k), dram_io_pad_enable, (k >= 1 && k <= 4) || k == 7);
`else
      chk($sformatf("ta_en%0d", k), dram_io_pad_enable, (k >= 1));
`endif
      chk($sformatf("ta_rdd%0d", k), sched_rd_done, (k == 5));
    end
    for (int k = 0; k < 6; k++) tick();
    chk("ta_idle", sched_busy, 1'b0);

    // Config shadowing while idle and while busy
    cfg_bl4     = 1'b1;
    cfg_clk_inv = 1'b1;
    tick();
    chk("cfg_bl4_idle", burst_length_four, 1'b1);
    chk("cfg_inv_idle", dram_io_pad_clk_inv, 1'b1);
    cmd_if.cmd_rd  = 1'b1;
    cmd_if.cmd_vld = 1'b1;
    tick();
    cmd_if.cmd_vld = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 1) begin
        cfg_bl4     = 1'b0;
        cfg_clk_inv = 1'b0;
      end
      chk($sformatf("sh_bl4_%0d", k), burst_length_four, (k < 4));
      chk($sformatf("sh_inv_%0d", k), dram_io_pad_clk_inv, (k < 4));
      chk($sformatf("sh_en_%0d", k), dram_io_pad_enable, (k == 1 || k == 2));
    end

    // Reset in the second burst cycle with overflow pending
    cfg_bl4    = 1'b1;
    cfg_rd_lat = 4'd3;
    tick();
    tick();
    cmd_if.cmd_rd  = 1'b1;
    cmd_if.cmd_vld = 1'b1;
    tick();
    tick();
    tick();
    chk("mr_rdy_full", cmd_if.cmd_rdy, 1'b0);
    tick();
    cmd_if.cmd_vld = 1'b0;
    chk("mr_ovf", sched_ovf, 1'b1);
    tick();
    chk("mr_en_k4", dram_io_pad_enable, 1'b1);
    tick();
    chk("mr_en_k5", dram_io_pad_enable, 1'b1);
    arst_l = 1'b0;
    #1;
    chk("mr_en", dram_io_pad_enable, 1'b0);
    chk("mr_rdd", sched_rd_done, 1'b0);
    chk("mr_ovf_clr", sched_ovf, 1'b0);
    chk("mr_rdy", cmd_if.cmd_rdy, 1'b1);
    chk("mr_busy", sched_busy, 1'b0);
    #2;
    arst_l = 1'b1;
    run_rd3("post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
